// File: rtl/pow2_mitchell_pipe.sv
`default_nettype none
// ============================================================================
// Module  : pow2_mitchell_pipe
// Brief   : Mitchell linear antilog, 2^(n+f) ~ (1+f)*2^n, as a 5-stage
//           registered barrel shift (16, 8, 4, 2, 1) with valid/ready flow.
// Revision: 1.0  initial release
// ============================================================================
module pow2_mitchell_pipe #(
    parameter int FRAC_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enb,
    input  logic [FRAC_BITS+4:0] i_LOG2,
    input  logic                 i_VALID,
    output logic                 o_READY,
    output logic [31:0]          o_WORD,
    output logic                 o_VALID,
    input  logic                 i_READY
);

    localparam int c_WORK_W = 32 + FRAC_BITS + 1;

    // Stages 4..1 carry the shift data and the exponent bits still to apply;
    // stage 0 keeps only the truncated integer word.
    logic [c_WORK_W-1:0] r_w [1:4];
    logic [3:0]          r_n [1:4];
    logic [4:1]          r_v;
    logic [31:0]         r_word0;
    logic                r_v0;

    logic                w_adv;
    logic [c_WORK_W-1:0] w_load;
    logic [c_WORK_W-1:0] w_s0;
    logic                w_unused_bits;

    assign w_adv   = enb & (~r_v0 | i_READY);
    assign w_load  = {{(c_WORK_W-FRAC_BITS-1){1'b0}}, 1'b1, i_LOG2[FRAC_BITS-1:0]};
    assign w_s0    = r_n[1][0] ? (r_w[1] << 1) : r_w[1];

    assign o_READY = w_adv;
    assign o_WORD  = r_word0;
    assign o_VALID = r_v0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= 4; k++) begin
                r_w[k] <= '0;
                r_n[k] <= '0;
            end
            r_v     <= '0;
            r_word0 <= '0;
            r_v0    <= 1'b0;
        end else if (w_adv) begin
            r_v[4] <= i_VALID;
            if (i_VALID) begin
                r_n[4] <= i_LOG2[FRAC_BITS+3:FRAC_BITS];
                r_w[4] <= i_LOG2[FRAC_BITS+4] ? (w_load << 16) : w_load;
            end
            for (int k = 3; k >= 1; k--) begin
                r_w[k] <= r_n[k+1][k] ? (r_w[k+1] << (1 << k)) : r_w[k+1];
                r_n[k] <= r_n[k+1];
                r_v[k] <= r_v[k+1];
            end
            // Integer part only: fractional bits below the binary point are dropped.
            r_word0 <= w_s0[FRAC_BITS+31:FRAC_BITS];
            r_v0    <= r_v[1];
        end
    end

    assign w_unused_bits = ^{w_s0[c_WORK_W-1], w_s0[FRAC_BITS-1:0], r_n[1][3:1]};

endmodule
`default_nettype wire

// File: tb/tb_pow2_mitchell_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_pow2_mitchell_pipe
// Brief   : Self-checking bench for pow2_mitchell_pipe against a queue model.
// Revision: 1.0  initial release
// ============================================================================
module tb_pow2_mitchell_pipe;

    localparam int FRAC_BITS = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enb = 1'b1;
    logic [FRAC_BITS+4:0] i_LOG2 = '0;
    logic                 i_VALID = 1'b0;
    logic                 o_READY;
    logic [31:0]          o_WORD;
    logic                 o_VALID;
    logic                 i_READY = 1'b1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [31:0] val;
        int unsigned t;
    } item_t;

    item_t       q[$];
    int unsigned adv_cnt = 0;

    pow2_mitchell_pipe #(.FRAC_BITS(FRAC_BITS)) dut (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .i_LOG2  (i_LOG2),
        .i_VALID (i_VALID),
        .o_READY (o_READY),
        .o_WORD  (o_WORD),
        .o_VALID (o_VALID),
        .i_READY (i_READY)
    );

    always #5 clk = ~clk;

    // floor((1 + f/2^FRAC_BITS) * 2^n)
    function automatic logic [31:0] antilog(input logic [FRAC_BITS+4:0] x);
        logic [63:0] p;
        p = 64'((1 << FRAC_BITS) + int'(x[FRAC_BITS-1:0])) << x[FRAC_BITS+4:FRAC_BITS];
        return p[FRAC_BITS+31:FRAC_BITS];
    endfunction

    // An item is visible once five advance edges have passed since its accept.
    function automatic logic m_valid();
        return (q.size() > 0) && ((adv_cnt - q[0].t) >= 5);
    endfunction

    function automatic logic m_adv();
        return enb && (!m_valid() || i_READY);
    endfunction

    // Advances one clock and updates the model; makes no comparisons.
    task automatic step();
        logic adv, pop, acc;
        adv = m_adv();
        pop = m_valid() && adv;
        acc = adv && i_VALID;
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{antilog(i_LOG2), adv_cnt});
            if (adv) adv_cnt++;
        end
        #1;
    endtask

    function automatic logic [FRAC_BITS+4:0] mk(input int n, input int f);
        logic [FRAC_BITS+4:0] v;
        v = {5'(n), 8'(f)};
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; i_VALID = 1'b0; enb = 1'b1; i_READY = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if (o_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", o_VALID); else passes++;
        checks++; if (o_WORD !== 32'd0) $display("FAIL reset_word got %h want 0", o_WORD); else passes++;
        checks++; if (o_READY !== 1'b1) $display("FAIL reset_ready got %b want 1", o_READY); else passes++;
    endtask

    task automatic test_basic();
        logic [FRAC_BITS+4:0] ins [5];
        logic [31:0] exp_tab [5];
        logic [31:0] got [5];
        int          got_cyc [5];
        int          nout;
        ins[0] = mk(0, 8'h00); exp_tab[0] = 32'd1;
        ins[1] = mk(4, 8'h40); exp_tab[1] = 32'd20;
        ins[2] = mk(3, 8'h80); exp_tab[2] = 32'd12;
        ins[3] = mk(0, 8'hFF); exp_tab[3] = 32'd1;
        ins[4] = mk(31, 8'hFF); exp_tab[4] = 32'hFF800000;
        nout = 0;
        i_READY = 1'b1;
        for (int c = 0; c < 14; c++) begin
            i_VALID = (c < 5);
            i_LOG2  = (c < 5) ? ins[c] : '0;
            #1;
            if (o_VALID && nout < 5) begin
                got[nout] = o_WORD; got_cyc[nout] = c; nout++;
            end
            step();
        end
        i_VALID = 1'b0;
        checks++; if (nout !== 5) $display("FAIL basic_count got %0d want 5", nout); else passes++;
        for (int k = 0; k < 5 && k < nout; k++) begin
            checks++;
            if (got[k] !== exp_tab[k]) $display("FAIL basic_word[%0d] got %h want %h", k, got[k], exp_tab[k]);
            else passes++;
            checks++;
            if (got_cyc[k] !== k + 5) $display("FAIL basic_latency[%0d] got cycle %0d want %0d", k, got_cyc[k], k + 5);
            else passes++;
        end
    endtask

    task automatic test_truncation();
        int seen;
        seen = 0;
        i_READY = 1'b1;
        for (int c = 0; c < 8; c++) begin
            i_VALID = (c == 0);
            i_LOG2  = mk(7, 8'h01);
            #1;
            if (o_VALID) begin
                seen++;
                checks++;
                if (o_WORD !== 32'd128) $display("FAIL trunc_word got %0d want 128", o_WORD);
                else passes++;
            end
            step();
        end
        i_VALID = 1'b0;
        checks++; if (seen !== 1) $display("FAIL trunc_count got %0d want 1", seen); else passes++;
    endtask

    task automatic test_backpressure();
        int sent, delivered, stall_left;
        bit stalled_once;
        sent = 0; delivered = 0; stall_left = 0; stalled_once = 0;
        for (int c = 0; c < 40; c++) begin
            if (o_VALID && !stalled_once) begin stall_left = 3; stalled_once = 1; end
            i_READY = (stall_left == 0);
            i_VALID = (sent < 8);
            i_LOG2  = FRAC_BITS'(0) | 13'($urandom_range(0, 8191));
            #1;
            checks++; if (o_READY !== m_adv()) $display("FAIL bp_ready got %b want %b", o_READY, m_adv()); else passes++;
            checks++; if (o_VALID !== m_valid()) $display("FAIL bp_valid got %b want %b", o_VALID, m_valid()); else passes++;
            if (m_valid()) begin
                checks++;
                if (o_WORD !== q[0].val) $display("FAIL bp_word got %h want %h", o_WORD, q[0].val);
                else passes++;
            end
            if (i_VALID && o_READY) sent++;
            if (o_VALID && i_READY) delivered++;
            step();
            if (stall_left > 0) stall_left--;
        end
        i_VALID = 1'b0; i_READY = 1'b1;
        checks++; if (delivered !== 8) $display("FAIL bp_delivered got %0d want 8", delivered); else passes++;
    endtask

    task automatic test_bubbles();
        logic pat [14];
        logic obs [14];
        for (int c = 0; c < 14; c++) pat[c] = (c < 5) ? ((c % 2) == 0) : 1'b0;
        i_READY = 1'b1;
        for (int c = 0; c < 14; c++) begin
            i_VALID = pat[c];
            i_LOG2  = 13'($urandom_range(0, 8191));
            #1;
            obs[c] = o_VALID;
            step();
        end
        i_VALID = 1'b0;
        for (int c = 0; c < 14; c++) begin
            logic want;
            want = (c >= 5) ? pat[c-5] : 1'b0;
            checks++;
            if (obs[c] !== want) $display("FAIL bubble_valid[%0d] got %b want %b", c, obs[c], want);
            else passes++;
        end
    endtask

    task automatic test_enb();
        logic [31:0] held_word;
        logic        held_valid;
        i_READY = 1'b1;
        for (int c = 0; c < 20; c++) begin
            enb     = !(c >= 7 && c < 11);
            i_VALID = (c < 12);
            i_LOG2  = 13'($urandom_range(0, 8191));
            if (c == 7) begin held_word = o_WORD; held_valid = o_VALID; end
            #1;
            checks++; if (o_READY !== m_adv()) $display("FAIL enb_ready got %b want %b", o_READY, m_adv()); else passes++;
            checks++; if (o_VALID !== m_valid()) $display("FAIL enb_valid got %b want %b", o_VALID, m_valid()); else passes++;
            if (m_valid()) begin
                checks++;
                if (o_WORD !== q[0].val) $display("FAIL enb_word got %h want %h", o_WORD, q[0].val);
                else passes++;
            end
            if (!enb) begin
                checks++;
                if (o_WORD !== held_word || o_VALID !== held_valid)
                    $display("FAIL enb_frozen got %h/%b want %h/%b", o_WORD, o_VALID, held_word, held_valid);
                else passes++;
            end
            step();
        end
        enb = 1'b1; i_VALID = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        i_READY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_VALID = 1'b1;
            i_LOG2  = 13'($urandom_range(0, 8191));
            step();
        end
        i_VALID = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (o_VALID !== 1'b0) $display("FAIL rstmid_valid got %b want 0", o_VALID); else passes++;
        checks++; if (o_WORD !== 32'd0) $display("FAIL rstmid_word got %h want 0", o_WORD); else passes++;
        checks++; if (o_READY !== 1'b1) $display("FAIL rstmid_ready got %b want 1", o_READY); else passes++;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            i_VALID = (c == 0);
            i_LOG2  = mk(1, 0);
            #1;
            checks++;
            if (o_VALID !== (c == 5)) $display("FAIL rstmid_timing[%0d] got %b want %b", c, o_VALID, (c == 5));
            else passes++;
            if (o_VALID) begin
                seen++;
                checks++;
                if (o_WORD !== 32'd2) $display("FAIL rstmid_word2 got %0d want 2", o_WORD);
                else passes++;
            end
            step();
        end
        i_VALID = 1'b0;
        checks++; if (seen !== 1) $display("FAIL rstmid_count got %0d want 1", seen); else passes++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            enb     = ($urandom_range(0, 9) != 0);
            i_VALID = ($urandom_range(0, 9) < 6);
            i_READY = ($urandom_range(0, 9) < 7);
            i_LOG2  = 13'($urandom_range(0, 8191));
            #1;
            checks++; if (o_READY !== m_adv()) $display("FAIL rand_ready got %b want %b", o_READY, m_adv()); else passes++;
            checks++; if (o_VALID !== m_valid()) $display("FAIL rand_valid got %b want %b", o_VALID, m_valid()); else passes++;
            if (m_valid()) begin
                checks++;
                if (o_WORD !== q[0].val) $display("FAIL rand_word got %h want %h", o_WORD, q[0].val);
                else passes++;
            end
            step();
        end
        enb = 1'b1; i_VALID = 1'b0; i_READY = 1'b1;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_truncation();
        test_backpressure();
        test_bubbles();
        test_enb();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pow2_mitchell_pipe.md
Name: pow2_mitchell_pipe

Overview:
- Fixed-point antilog (2^x) block; the inverse path of the log2 fixed-point datapath and its CLZ normalisation stages.
- Takes an unsigned log2 value in Q5.FRAC_BITS format and reconstructs a uint32 using Mitchell's linear antilog: 2^(n+f) ≈ (1+f)·2^n.
- Built as a 5-stage registered barrel-shift pipeline (shift by 16, 8, 4, 2, 1). This mirrors the CLZ stage order in reverse.
- Valid/ready handshake on both sides; sits downstream of log-domain arithmetic (scaling, multiply-by-add) feeding linear-domain consumers.

Parameters:
- FRAC_BITS, 8, fractional bits of input log2 value; internal work width = 32+FRAC_BITS+1.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enb  input  1  clock enable; when low, all state holds.
- i_LOG2  input  5+FRAC_BITS  unsigned log2 value; [FRAC_BITS+4:FRAC_BITS] = integer n (0..31); [FRAC_BITS-1:0] = fraction f.
- i_VALID  input  1  i_LOG2 valid.
- o_READY  output  1  block accepts i_LOG2 this cycle.
- o_WORD  output  32  uint32 result.
- o_VALID  output  1  o_WORD valid.
- i_READY  input  1  downstream accepts o_WORD.

Behaviour:
- Reset: synchronous, active-high. Takes effect on the clock edge regardless of enb.
  - All stage valid bits clear; all stage data registers clear.
  - o_VALID=0, o_WORD=0.
  - Reset mid-operation discards every in-flight item; nothing is emitted after reset deasserts until new input is accepted.
- advance = enb & (~o_VALID | i_READY). o_READY = advance, combinational; no dependency on i_VALID.
- Accept: edge where advance & i_VALID. Stage-4 register loads:
  - W = {1'b1, f}, zero-extended to the work width;
  - n, if n[4] then W<<16.
  - Stage-4 valid = i_VALID & advance.
- Each advance edge moves every stage forward one slot, bubbles included:
  - stage3 = stage4 data shifted <<8 if n[3];
  - stage2 shifts <<4 if n[2];
  - stage1 shifts <<2 if n[1];
  - stage0 shifts <<1 if n[0].
  - n travels with its data; valid bits travel with data.
- No advance: all stages hold (full-pipe stall); o_WORD and o_VALID stable.
- Output: o_WORD = stage0 W[FRAC_BITS+31:FRAC_BITS], i.e. integer part truncated, not rounded. o_VALID = stage0 valid.
- Latency: exactly 5 advance edges from accept to o_VALID=1. Throughput: 1 item per cycle with i_READY held high.
- Bubbles are not collapsed. A stall with o_VALID=0 cannot occur, because advance=1 whenever o_VALID=0 and enb=1.
- Arithmetic:
  - Maximum shift is 31, so W spans at most FRAC_BITS+32 bits.
  - n=31 places the hidden 1 at o_WORD[31]; no overflow and no saturation needed.
  - n < FRAC_BITS drops fractional bits, so result = floor((1+f/2^FRAC_BITS)·2^n).
- Simultaneous events:
  - Accept and output handshake in the same cycle is legal; ordering is preserved.
  - reset has priority over enb and all handshakes.
  - enb low freezes everything, including o_READY=0.
- o_WORD while o_VALID=0: holds the last stage0 data (0 after reset); consumers must not sample it.

Test Plan:
- Basic values, i_READY=1, FRAC_BITS=8, issued back-to-back one per cycle:
  - n=0,f=0x00 -> 1
  - n=4,f=0x40 -> 20
  - n=3,f=0x80 -> 12
  - n=0,f=0xFF -> 1
  - n=31,f=0xFF -> 0xFF800000
  - Each result appears in order, 5 cycles after its accept, on consecutive cycles.
- Truncation: n=7,f=0x01 -> 128 (257·128/256 = 128.5 truncated).
- Backpressure:
  - Stream 8 values; drop i_READY for 3 cycles while o_VALID=1.
  - Required: o_READY=0, o_WORD/o_VALID held stable, no loss or duplication.
  - All 8 results delivered in order after i_READY returns.
- Bubbles: i_VALID pattern 1,0,1,0,1 -> o_VALID pattern 1,0,1,0,1 starting 5 cycles later.
- enb gating: drop enb for 4 cycles mid-stream -> all state frozen, o_READY=0; the stream resumes unchanged.
- Reset mid-operation:
  - Assert reset for 1 cycle with 3 items in flight.
  - Next cycle: o_VALID=0, o_WORD=0, o_READY=1; no stale items ever emerge.
  - A fresh item n=1,f=0 -> 2 after 5 cycles.
